// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth datapath: FSM state encoding, partial-product
// select encoding and the Booth recode lookup.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  typedef enum logic [2:0] {
    PP_ZERO,
    PP_POS1,
    PP_POS2,
    PP_NEG1,
    PP_NEG2
  } pp_sel_e;

  // Window is {b[2i+1], b[2i], b[2i-1]}.
  function automatic pp_sel_e booth_recode(input logic [2:0] win);
    pp_sel_e sel;
    sel = PP_ZERO;
    case (win)
      3'b001, 3'b010: sel = PP_POS1;
      3'b011:         sel = PP_POS2;
      3'b100:         sel = PP_NEG2;
      3'b101, 3'b110: sel = PP_NEG1;
      default:        sel = PP_ZERO;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/cla4_carry.sv
// 4-bit carry-lookahead block: bit carries and group carry-out from per-bit p/g.
module cla4_carry (
  input  logic [3:0] p,
  input  logic [3:0] g,
  input  logic       cin,
  output logic [3:1] c,
  output logic       cout
);

  always_comb begin
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
  end

endmodule

// File: rtl/cla_add_n.sv
// N-bit adder (N a multiple of 4) built from 4-bit CLA groups with rippled group carries.
module cla_add_n #(
  parameter int N = 20
) (
  input  logic [N-1:0] x,
  input  logic [N-1:0] y,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  localparam int NG = N / 4;

  logic [N-1:0] p;
  logic [N-1:0] g;
  logic [N:0]   c;

  always_comb begin
    p = x ^ y;
    g = x & y;
  end

  assign c[0] = cin;

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    cla4_carry u_cla4 (
      .p    (p[4*gi+3 : 4*gi]),
      .g    (g[4*gi+3 : 4*gi]),
      .cin  (c[4*gi]),
      .c    (c[4*gi+3 : 4*gi+1]),
      .cout (c[4*gi+4])
    );
  end

  always_comb begin
    sum  = p ^ c[N-1:0];
    cout = c[N];
  end

endmodule

// File: rtl/booth_r4_seq_mult.sv
// Sequential signed radix-4 Booth multiplier: two multiplier bits retired per clock,
// start/busy/done handshake, product held until the next result.
module booth_r4_seq_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int ITER = WIDTH / 2;
  localparam int AW   = WIDTH + 2;
  localparam int DW   = ((AW + 3) / 4) * 4;
  localparam int CW   = $clog2(ITER);
  localparam logic [CW-1:0] COUNT_INIT = CW'(ITER - 1);

  state_e               state_q, state_d;
  logic [AW-1:0]        m_q, m_d;
  logic [AW-1:0]        acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]     acc_lo_q, acc_lo_d;
  logic                 prev_q, prev_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  pp_sel_e              pp_sel;
  logic [AW-1:0]        m2;
  logic [AW-1:0]        pp;
  logic                 pp_cin;
  logic [DW-1:0]        add_x, add_y;
  logic [AW-1:0]        add_sum;
  logic [DW-AW-1:0]     add_pad_unused;
  logic                 add_cout_unused;
  logic [AW-1:0]        shift_hi;
  logic [WIDTH-1:0]     shift_lo;

  // Negative multiples are one's-complemented here; the +1 enters as the adder carry-in.
  always_comb begin
    pp_sel = booth_recode({acc_lo_q[1:0], prev_q});
    m2     = {m_q[AW-2:0], 1'b0};
    pp     = '0;
    pp_cin = 1'b0;
    case (pp_sel)
      PP_POS1: pp = m_q;
      PP_POS2: pp = m2;
      PP_NEG1: begin pp = ~m_q; pp_cin = 1'b1; end
      PP_NEG2: begin pp = ~m2;  pp_cin = 1'b1; end
      default: pp = '0;
    endcase
    add_x = {{(DW-AW){acc_hi_q[AW-1]}}, acc_hi_q};
    add_y = {{(DW-AW){pp[AW-1]}}, pp};
  end

  cla_add_n #(.N(DW)) u_add (
    .x    (add_x),
    .y    (add_y),
    .cin  (pp_cin),
    .sum  ({add_pad_unused, add_sum}),
    .cout (add_cout_unused)
  );

  always_comb begin
    shift_hi = {{2{add_sum[AW-1]}}, add_sum[AW-1:2]};
    shift_lo = {add_sum[1:0], acc_lo_q[WIDTH-1:2]};
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    prev_d    = prev_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          m_d      = {{2{a[WIDTH-1]}}, a};
          acc_hi_d = '0;
          acc_lo_d = b;
          prev_d   = 1'b0;
          count_d  = COUNT_INIT;
          state_d  = RUN;
        end
      end
      RUN: begin
        acc_hi_d = shift_hi;
        acc_lo_d = shift_lo;
        prev_d   = acc_lo_q[1];
        count_d  = count_q - CW'(1);
        if (count_q == '0) begin
          state_d   = DONE;
          product_d = {shift_hi[WIDTH-1:0], shift_lo};
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      m_q       <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      prev_q    <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      prev_q    <= prev_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);
    product = product_q;
  end

endmodule
